// File: rtl/nnrv_dmem_pkg.sv
// Shared definitions for the nnrv data-side responder: MMIO register map,
// address-region and register enums, and byte-lane merge helpers.
package nnrv_dmem_pkg;

  localparam int unsigned MMIO_WINDOW_BYTES = 4096;

  localparam logic [11:0] MMIO_MTIME_LO    = 12'h000;
  localparam logic [11:0] MMIO_MTIME_HI    = 12'h004;
  localparam logic [11:0] MMIO_MTIMECMP_LO = 12'h008;
  localparam logic [11:0] MMIO_MTIMECMP_HI = 12'h00C;
  localparam logic [11:0] MMIO_TOHOST      = 12'h010;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_TOHOST,
    REG_NONE
  } mmio_reg_e;

  // Word offset within the window (byte offset bits [11:2]) to register.
  function automatic mmio_reg_e mmio_reg_decode(input logic [9:0] word_off);
    case ({word_off, 2'b00})
      MMIO_MTIME_LO:    return REG_MTIME_LO;
      MMIO_MTIME_HI:    return REG_MTIME_HI;
      MMIO_MTIMECMP_LO: return REG_MTIMECMP_LO;
      MMIO_MTIMECMP_HI: return REG_MTIMECMP_HI;
      MMIO_TOHOST:      return REG_TOHOST;
      default:          return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] lane_expand(input logic [3:0] mask);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    return (old_word & ~lane_expand(mask)) | (new_word & lane_expand(mask));
  endfunction

endpackage

// File: rtl/nnrv_dmem_ram.sv
// Word-organised data RAM: byte-lane write enables and asynchronous read.
module nnrv_dmem_ram #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           i_clk,
  input  logic                           i_wr_en,
  input  logic [XLEN/8-1:0]              i_wr_mask,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_wr_idx,
  input  logic [XLEN-1:0]                i_wr_data,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_rd_idx,
  output logic [XLEN-1:0]                o_rd_data
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // NOTE: the array has no reset branch; resetting a memory turns it into
  // thousands of flops instead of a RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int lane = 0; lane < XLEN/8; lane++) begin
        if (i_wr_mask[lane]) begin
          mem_q[i_wr_idx][8*lane +: 8] <= i_wr_data[8*lane +: 8];
        end
      end
    end
  end

  assign o_rd_data = mem_q[i_rd_idx];

endmodule

// File: rtl/nnrv_dmem.sv
// Data-side responder for the MEM stage: RAM loads/stores plus an MMIO
// window holding the machine timer and the tohost/halt register.
module nnrv_dmem
  import nnrv_dmem_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE   = 32'h8000_0000,
  parameter string           INIT_FILE   = ""
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_ram_rd_addr,
  input  logic            i_ram_rd_en,
  input  logic [3:0]      i_ram_rd_mask,
  output logic [XLEN-1:0] o_ram_rd_data,
  input  logic [XLEN-1:0] i_ram_wr_addr,
  input  logic            i_ram_wr_en,
  input  logic [3:0]      i_ram_wr_mask,
  input  logic [XLEN-1:0] i_ram_wr_data,
  output logic            o_timer_irq,
  output logic [XLEN-1:0] o_tohost,
  output logic            o_halt,
  output logic            o_bus_err
);

  localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-3:0] RAM_WORDS = (XLEN-2)'(DEPTH_WORDS);

  function automatic region_e decode_region(input logic [XLEN-1:0] addr);
    if (addr[XLEN-1:2] < RAM_WORDS) return REGION_RAM;
    if (addr[XLEN-1:12] == MMIO_BASE[XLEN-1:12]) return REGION_MMIO;
    return REGION_NONE;
  endfunction

  region_e         rd_region, wr_region;
  mmio_reg_e       rd_reg, wr_reg;
  logic [XLEN-1:0] ram_rd_word, mmio_rd_word;
  logic            ram_wr_en;

  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic [XLEN-1:0] tohost_q, tohost_d;
  logic            halt_q, halt_d;
  logic            irq_q, irq_d;
  logic            bus_err_q, bus_err_d;

  // Load lanes are selected by the initiator; the low address bits only
  // matter to it, since every access is treated as a word access.
  logic unused_lane_info;
  assign unused_lane_info = ^{i_ram_rd_mask, i_ram_rd_addr[1:0], i_ram_wr_addr[1:0]};

  always_comb begin
    rd_region = decode_region(i_ram_rd_addr);
    wr_region = decode_region(i_ram_wr_addr);
    rd_reg    = mmio_reg_decode(i_ram_rd_addr[11:2]);
    wr_reg    = mmio_reg_decode(i_ram_wr_addr[11:2]);
  end

  // A write still in flight when reset asserts must not reach the array.
  assign ram_wr_en = i_ram_wr_en && (wr_region == REGION_RAM) && !i_rst;

  nnrv_dmem_ram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (ram_wr_en),
    .i_wr_mask (i_ram_wr_mask),
    .i_wr_idx  (i_ram_wr_addr[AW+1:2]),
    .i_wr_data (i_ram_wr_data),
    .i_rd_idx  (i_ram_rd_addr[AW+1:2]),
    .o_rd_data (ram_rd_word)
  );

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mmio_rd_word = '0;
    case (rd_reg)
      REG_MTIME_LO:    mmio_rd_word = mtime_q[31:0];
      REG_MTIME_HI:    mmio_rd_word = mtime_q[63:32];
      REG_MTIMECMP_LO: mmio_rd_word = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: mmio_rd_word = mtimecmp_q[63:32];
      REG_TOHOST:      mmio_rd_word = tohost_q;
      default:         mmio_rd_word = '0;
    endcase

    o_ram_rd_data = '0;
    if (i_ram_rd_en) begin
      if (rd_region == REGION_RAM) begin
        o_ram_rd_data = ram_rd_word;
      end else if (rd_region == REGION_MMIO) begin
        o_ram_rd_data = mmio_rd_word;
      end
    end
  end

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    tohost_d   = tohost_q;
    halt_d     = halt_q;

    // An all-zero lane mask changes nothing, so the timer keeps counting.
    if (i_ram_wr_en && (wr_region == REGION_MMIO) && (i_ram_wr_mask != 4'b0000)) begin
      case (wr_reg)
        REG_MTIME_LO: mtime_d = {mtime_q[63:32],
                                 merge_lanes(mtime_q[31:0], i_ram_wr_data, i_ram_wr_mask)};
        REG_MTIME_HI: mtime_d = {merge_lanes(mtime_q[63:32], i_ram_wr_data, i_ram_wr_mask),
                                 mtime_q[31:0]};
        REG_MTIMECMP_LO: mtimecmp_d[31:0] =
          merge_lanes(mtimecmp_q[31:0], i_ram_wr_data, i_ram_wr_mask);
        REG_MTIMECMP_HI: mtimecmp_d[63:32] =
          merge_lanes(mtimecmp_q[63:32], i_ram_wr_data, i_ram_wr_mask);
        REG_TOHOST: begin
          tohost_d = merge_lanes(tohost_q, i_ram_wr_data, i_ram_wr_mask);
          halt_d   = halt_q || (tohost_d != '0);
        end
        default: ;
      endcase
    end

    irq_d     = (mtime_q >= mtimecmp_q);
    bus_err_d = bus_err_q
             || (i_ram_rd_en && (rd_region == REGION_NONE))
             || (i_ram_wr_en && (wr_region == REGION_NONE));
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      tohost_q   <= '0;
      halt_q     <= 1'b0;
      irq_q      <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      tohost_q   <= tohost_d;
      halt_q     <= halt_d;
      irq_q      <= irq_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign o_timer_irq = irq_q;
  assign o_tohost    = tohost_q;
  assign o_halt      = halt_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_nnrv_dmem.sv
// Self-checking bench for nnrv_dmem: directed literal checks plus random
// traffic compared every cycle against a behavioural model.
module tb_nnrv_dmem;
  import nnrv_dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_ram_rd_addr = '0;
  logic        i_ram_rd_en = 1'b0;
  logic [3:0]  i_ram_rd_mask = 4'hF;
  logic [31:0] o_ram_rd_data;
  logic [31:0] i_ram_wr_addr = '0;
  logic        i_ram_wr_en = 1'b0;
  logic [3:0]  i_ram_wr_mask = '0;
  logic [31:0] i_ram_wr_data = '0;
  logic        o_timer_irq;
  logic [31:0] o_tohost;
  logic        o_halt;
  logic        o_bus_err;

  nnrv_dmem #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (BASE),
    .INIT_FILE   ("")
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ram_rd_addr (i_ram_rd_addr),
    .i_ram_rd_en   (i_ram_rd_en),
    .i_ram_rd_mask (i_ram_rd_mask),
    .o_ram_rd_data (o_ram_rd_data),
    .i_ram_wr_addr (i_ram_wr_addr),
    .i_ram_wr_en   (i_ram_wr_en),
    .i_ram_wr_mask (i_ram_wr_mask),
    .i_ram_wr_data (i_ram_wr_data),
    .o_timer_irq   (o_timer_irq),
    .o_tohost      (o_tohost),
    .o_halt        (o_halt),
    .o_bus_err     (o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram   [DEPTH];
  bit          m_known [DEPTH];
  logic [63:0] m_mtime  = '0;
  logic [63:0] m_cmp    = '1;
  logic        m_irq    = 1'b0;
  logic [31:0] m_tohost = '0;
  logic        m_halt   = 1'b0;
  logic        m_err    = 1'b0;

  logic        t_irq, t_held;
  logic [31:0] t_bits;
  int unsigned t_w;

  function automatic logic [31:0] byte_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return (a / 4) < DEPTH;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a / MMIO_WINDOW_BYTES) == (BASE / MMIO_WINDOW_BYTES);
  endfunction

  // {known, value} of what a load must return given current model state.
  function automatic logic [32:0] model_rd(input logic en, input logic [31:0] a);
    logic [11:0] off;
    if (!en) return {1'b1, 32'h0};
    if (is_ram(a)) return {m_known[a / 4], m_ram[a / 4]};
    if (is_mmio(a)) begin
      off = (a % MMIO_WINDOW_BYTES) & ~12'h3;
      case (off)
        MMIO_MTIME_LO:    return {1'b1, m_mtime[31:0]};
        MMIO_MTIME_HI:    return {1'b1, m_mtime[63:32]};
        MMIO_MTIMECMP_LO: return {1'b1, m_cmp[31:0]};
        MMIO_MTIMECMP_HI: return {1'b1, m_cmp[63:32]};
        MMIO_TOHOST:      return {1'b1, m_tohost};
        default:          return {1'b1, 32'h0};
      endcase
    end
    return {1'b1, 32'h0};
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_mtime  = '0;
      m_cmp    = '1;
      m_irq    = 1'b0;
      m_tohost = '0;
      m_halt   = 1'b0;
      m_err    = 1'b0;
    end else begin
      t_irq  = (m_mtime >= m_cmp);
      t_held = 1'b0;
      if (i_ram_rd_en && !is_ram(i_ram_rd_addr) && !is_mmio(i_ram_rd_addr)) m_err = 1'b1;
      if (i_ram_wr_en) begin
        t_bits = byte_bits(i_ram_wr_mask);
        if (is_ram(i_ram_wr_addr)) begin
          t_w = i_ram_wr_addr / 4;
          m_ram[t_w] = (m_ram[t_w] & ~t_bits) | (i_ram_wr_data & t_bits);
          if (i_ram_wr_mask == 4'hF) m_known[t_w] = 1'b1;
        end else if (is_mmio(i_ram_wr_addr)) begin
          if (i_ram_wr_mask != 4'h0) begin
            case ((i_ram_wr_addr % MMIO_WINDOW_BYTES) & ~32'h3)
              32'(MMIO_MTIME_LO): begin
                m_mtime[31:0] = (m_mtime[31:0] & ~t_bits) | (i_ram_wr_data & t_bits);
                t_held = 1'b1;
              end
              32'(MMIO_MTIME_HI): begin
                m_mtime[63:32] = (m_mtime[63:32] & ~t_bits) | (i_ram_wr_data & t_bits);
                t_held = 1'b1;
              end
              32'(MMIO_MTIMECMP_LO): m_cmp[31:0]  = (m_cmp[31:0]  & ~t_bits) | (i_ram_wr_data & t_bits);
              32'(MMIO_MTIMECMP_HI): m_cmp[63:32] = (m_cmp[63:32] & ~t_bits) | (i_ram_wr_data & t_bits);
              32'(MMIO_TOHOST): begin
                m_tohost = (m_tohost & ~t_bits) | (i_ram_wr_data & t_bits);
                if (m_tohost != 0) m_halt = 1'b1;
              end
              default: ;
            endcase
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (!t_held) m_mtime = m_mtime + 64'd1;
      m_irq = t_irq;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        chk_on = 1'b0;
  logic [32:0] t_exp;

  always @(negedge i_clk) begin
    if (chk_on && !i_rst) begin
      t_exp = model_rd(i_ram_rd_en, i_ram_rd_addr);
      if (t_exp[32]) check("model_rd_data", o_ram_rd_data, t_exp[31:0]);
      check("model_irq", {31'b0, o_timer_irq}, {31'b0, m_irq});
      check("model_tohost", o_tohost, m_tohost);
      check("model_halt", {31'b0, o_halt}, {31'b0, m_halt});
      check("model_bus_err", {31'b0, o_bus_err}, {31'b0, m_err});
    end
  end

  // ---------------- drivers ----------------
  task automatic apply(input logic re, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [3:0] wm, input logic [31:0] wd);
    @(posedge i_clk);
    #1;
    i_ram_rd_en   = re;
    i_ram_rd_addr = ra;
    i_ram_rd_mask = 4'hF;
    i_ram_wr_en   = we;
    i_ram_wr_addr = wa;
    i_ram_wr_mask = wm;
    i_ram_wr_data = wd;
    @(negedge i_clk);
  endtask

  task automatic rd(input logic [31:0] a);
    apply(1'b1, a, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    apply(1'b0, 32'h0, 1'b1, a, m, d);
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic reset_pulse(input logic write_during);
    @(negedge i_clk);
    i_rst         = 1'b1;
    i_ram_rd_en   = 1'b0;
    i_ram_wr_en   = write_during;
    i_ram_wr_addr = 32'h80;
    i_ram_wr_mask = 4'hF;
    i_ram_wr_data = 32'h3333_3333;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst       = 1'b0;
    i_ram_wr_en = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 199);
    if (r < 100)      a = 32'($urandom_range(0, 15)) << 2;
    else if (r < 115) a = 32'hFFC;
    else if (r < 197) a = BASE + (32'($urandom_range(0, 6)) << 2);
    else if (r < 198) a = 32'h1000;
    else              a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] v;
    bit          seen20, seen21;
    logic [31:0] ra, wa;

    #2 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset_irq", {31'b0, o_timer_irq}, 32'h0);
    check("reset_tohost", o_tohost, 32'h0);
    check("reset_halt", {31'b0, o_halt}, 32'h0);
    check("reset_bus_err", {31'b0, o_bus_err}, 32'h0);
    check("reset_rd_idle", o_ram_rd_data, 32'h0);
    i_rst  = 1'b0;
    chk_on = 1'b1;

    rd(BASE + 32'(MMIO_MTIME_LO));  check("mtime_first", o_ram_rd_data, 32'h1);
    rd(BASE + 32'(MMIO_MTIME_HI));  check("mtime_hi_first", o_ram_rd_data, 32'h0);
    rd(BASE + 32'(MMIO_MTIMECMP_LO)); check("mtimecmp_reset", o_ram_rd_data, 32'hFFFF_FFFF);

    wr(32'h40, 4'hF, 32'hDEAD_BEEF);
    rd(32'h40);                     check("store_full", o_ram_rd_data, 32'hDEAD_BEEF);
    wr(32'h40, 4'b0010, 32'h0000_AB00);
    rd(32'h40);                     check("store_lane1", o_ram_rd_data, 32'hDEAD_ABEF);
    wr(32'h40, 4'b0000, 32'hFFFF_FFFF);
    rd(32'h40);                     check("store_mask0", o_ram_rd_data, 32'hDEAD_ABEF);
    check("mask0_no_err", {31'b0, o_bus_err}, 32'h0);

    wr(32'h80, 4'hF, 32'h2222_2222);
    apply(1'b1, 32'h80, 1'b1, 32'h80, 4'hF, 32'h1111_1111);
    check("read_old", o_ram_rd_data, 32'h2222_2222);
    rd(32'h80);                     check("read_after", o_ram_rd_data, 32'h1111_1111);

    wr(32'hFFC, 4'hF, 32'hCAFE_F00D);
    rd(32'hFFE);                    check("last_word_misaligned", o_ram_rd_data, 32'hCAFE_F00D);
    rd(BASE + 32'h14);              check("mmio_hole", o_ram_rd_data, 32'h0);

    reset_pulse(1'b1);
    rd(32'h80);                     check("write_lost_in_reset", o_ram_rd_data, 32'h1111_1111);

    wr(BASE + 32'(MMIO_MTIMECMP_HI), 4'hF, 32'h0);
    wr(BASE + 32'(MMIO_MTIMECMP_LO), 4'hF, 32'd20);
    seen20 = 1'b0;
    seen21 = 1'b0;
    for (int i = 0; i < 200 && !seen21; i++) begin
      rd(BASE + 32'(MMIO_MTIME_LO));
      v = o_ram_rd_data;
      if (v == 32'd20) begin
        seen20 = 1'b1;
        check("irq_at_20", {31'b0, o_timer_irq}, 32'h0);
      end else if (v == 32'd21) begin
        seen21 = 1'b1;
        check("irq_at_21", {31'b0, o_timer_irq}, 32'h1);
      end
    end
    if (!(seen20 && seen21)) check("irq_poll_timeout", 32'h0, 32'h1);
    wr(BASE + 32'(MMIO_MTIMECMP_LO), 4'hF, 32'hFFFF_FFFF);
    check("irq_hold0", {31'b0, o_timer_irq}, 32'h1);
    idle();                         check("irq_hold1", {31'b0, o_timer_irq}, 32'h1);
    idle();                         check("irq_drop", {31'b0, o_timer_irq}, 32'h0);

    wr(BASE + 32'(MMIO_MTIME_HI), 4'hF, 32'h0);
    wr(BASE + 32'(MMIO_MTIME_LO), 4'hF, 32'hFFFF_FFFE);
    rd(BASE + 32'(MMIO_MTIME_LO));  check("mtime_no_inc", o_ram_rd_data, 32'hFFFF_FFFE);
    rd(BASE + 32'(MMIO_MTIME_HI));  check("mtime_hi_before", o_ram_rd_data, 32'h0);
    rd(BASE + 32'(MMIO_MTIME_LO));  check("mtime_lo_wrap", o_ram_rd_data, 32'h0);
    rd(BASE + 32'(MMIO_MTIME_HI));  check("mtime_hi_carry", o_ram_rd_data, 32'h1);

    wr(BASE + 32'(MMIO_TOHOST), 4'hF, 32'h0);
    idle();
    check("tohost_zero", o_tohost, 32'h0);
    check("halt_zero", {31'b0, o_halt}, 32'h0);
    wr(BASE + 32'(MMIO_TOHOST), 4'hF, 32'h1);
    idle();
    check("tohost_one", o_tohost, 32'h1);
    check("halt_set", {31'b0, o_halt}, 32'h1);
    rd(32'h4000_0000);
    check("bad_rd_data", o_ram_rd_data, 32'h0);
    check("bad_err_same_cycle", {31'b0, o_bus_err}, 32'h0);
    idle();                         check("bad_err_set", {31'b0, o_bus_err}, 32'h1);
    wr(BASE + 32'(MMIO_TOHOST), 4'hF, 32'h0);
    repeat (3) idle();
    check("bad_err_sticky", {31'b0, o_bus_err}, 32'h1);
    check("halt_sticky", {31'b0, o_halt}, 32'h1);
    check("tohost_rewrite", o_tohost, 32'h0);
    reset_pulse(1'b0);
    check("err_cleared", {31'b0, o_bus_err}, 32'h0);
    check("halt_cleared", {31'b0, o_halt}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) reset_pulse($urandom_range(0, 1) == 1);
      ra = pick_addr();
      wa = ($urandom_range(0, 4) == 0) ? ra : pick_addr();
      apply($urandom_range(0, 9) < 7, ra,
            $urandom_range(0, 1) == 1, wa,
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
            ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
